// File: rtl/game2048_move_ctrl.sv
// game2048_move_ctrl: turns four raw, bouncy, active-low push-buttons into
// clean, arbitrated, one-at-a-time move requests for the 2048 game FSM.
// Each request is held until the game FSM accepts it with ready.
// Optional feature: define MOVE_REPEAT_EN for hold-to-repeat moves.
//
// state    | meaning
// ---------|------------------------------------------------------------
// S_IDLE   | no move in flight, watching for a debounced press event
// S_PEND   | latched direction presented on move_*, waiting for ready
// S_WAIT_REL | move accepted, ignoring presses until all buttons released
module game2048_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic       ready,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       busy,
  output logic [7:0] move_count
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT_REL} state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_TC = DBW'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right
  logic [3:0]     w_raw;
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_db;
  logic [3:0]     r_db_prev;
  logic [DBW-1:0] r_db_cnt [4];
  logic [3:0]     w_press;
  logic [1:0]     w_win_dir;
  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_dir;
  logic [1:0]     w_dir_nxt;
  logic           w_accept;
  logic           w_rep_fire;

  assign w_raw = {~btn_right_n, ~btn_left_n, ~btn_down_n, ~btn_up_n};

  // Two-flop synchroniser on the inverted (active-high) button levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: accept a new level only after it has differed
  // from the stable level for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_TC) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Previous debounced level for rising-edge (press) detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_db_prev <= '0;
    else        r_db_prev <= r_db;
  end

  assign w_press = r_db & ~r_db_prev;

  // Fixed priority up > down > left > right; losers are simply dropped
  always_comb begin
    w_win_dir = 2'd3;
    if      (w_press[0]) w_win_dir = 2'd0;
    else if (w_press[1]) w_win_dir = 2'd1;
    else if (w_press[2]) w_win_dir = 2'd2;
  end

`ifdef MOVE_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_CYCLES);
  localparam logic [RPW-1:0] RP_TC = RPW'(REPEAT_CYCLES - 1);
  logic [RPW-1:0] r_rep_cnt;

  assign w_rep_fire = (r_state == S_WAIT_REL) && r_db[r_dir] && (r_rep_cnt == RP_TC);

  // Hold-to-repeat timer runs only while the latched button stays held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    r_rep_cnt <= '0;
    else if ((r_state == S_WAIT_REL) && r_db[r_dir]) r_rep_cnt <= w_rep_fire ? '0 : r_rep_cnt + 1'b1;
    else                                           r_rep_cnt <= '0;
  end
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  assign w_rep_fire = 1'b0;
`endif

  // FSM state, latched direction and accepted-move counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_dir      <= 2'd0;
      move_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      if (w_accept) move_count <= move_count + 8'd1;
    end
  end

  // Next-state logic; a repeat re-presents the same latched direction
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_press) begin
          w_state_nxt = S_PEND;
          w_dir_nxt   = w_win_dir;
        end
      end
      S_PEND: begin
        if (ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (w_rep_fire)     w_state_nxt = S_PEND;
        else if (r_db == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registers only
  always_comb begin
    busy       = (r_state != S_IDLE);
    move_up    = (r_state == S_PEND) && (r_dir == 2'd0);
    move_down  = (r_state == S_PEND) && (r_dir == 2'd1);
    move_left  = (r_state == S_PEND) && (r_dir == 2'd2);
    move_right = (r_state == S_PEND) && (r_dir == 2'd3);
  end

endmodule
